// File: rtl/rvfpm_result_queue.sv
// rtl/rvfpm_result_queue.sv - in-order FPU result queue gated by XIF commit/kill status
// A head entry is released once its ID is committed and dropped once its ID is killed.
module rvfpm_result_queue #(
  parameter int X_ID_WIDTH = 4,
  parameter int FLEN       = 32,
  parameter int DEPTH      = 4
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [X_ID_WIDTH-1:0]   in_id,
  input  logic [FLEN-1:0]         in_data,
  input  logic [4:0]              in_rd,
  input  logic                    in_we,
  input  logic                    in_exc,
  input  logic [5:0]              in_exccode,
  input  logic                    commit_valid,
  input  logic [X_ID_WIDTH-1:0]   commit_id,
  input  logic                    commit_kill,
  output logic                    result_valid,
  input  logic                    result_ready,
  output logic [X_ID_WIDTH-1:0]   result_id,
  output logic [FLEN-1:0]         result_data,
  output logic [4:0]              result_rd,
  output logic                    result_we,
  output logic                    result_exc,
  output logic [5:0]              result_exccode,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int NID   = 1 << X_ID_WIDTH;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic [FLEN-1:0]       data;
    logic [4:0]            rd;
    logic                  we;
    logic                  exc;
    logic [5:0]            exccode;
  } entry_t;

  entry_t             mem_q [DEPTH];
  entry_t             hold_q;
  entry_t             head;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [NID-1:0]     committed_q, committed_d;
  logic [NID-1:0]     killed_q, killed_d;
  logic               empty, full, push, pop;
  logic               head_drop, head_release;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));
  assign head  = mem_q[rd_ptr_q];

  // Kill outranks commit when both bits are set for the head ID.
  assign head_drop    = !empty && killed_q[head.id];
  assign head_release = !empty && committed_q[head.id] && !killed_q[head.id];

  assign push = in_valid && !full;
  assign pop  = head_drop || (head_release && result_ready);

  assign count_d = count_q + CNT_W'(push) - CNT_W'(pop);

  always_comb begin
    committed_d = committed_q;
    killed_d    = killed_q;
    if (pop) begin
      committed_d[head.id] = 1'b0;
      killed_d[head.id]    = 1'b0;
    end
    // A new commit/kill for the popped ID is a reuse, so it overrides the clear.
    if (commit_valid) begin
      if (commit_kill) killed_d[commit_id]    = 1'b1;
      else             committed_d[commit_id] = 1'b1;
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      hold_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      committed_q <= '0;
      killed_q    <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{id: in_id, data: in_data, rd: in_rd, we: in_we,
                             exc: in_exc, exccode: in_exccode};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (!empty) hold_q <= head;
      count_q     <= count_d;
      committed_q <= committed_d;
      killed_q    <= killed_d;
    end
  end

  entry_t out_e;
  assign out_e = empty ? hold_q : head;

  assign in_ready       = !full;
  assign result_valid   = head_release;
  assign result_id      = out_e.id;
  assign result_data    = out_e.data;
  assign result_rd      = out_e.rd;
  assign result_we      = out_e.we;
  assign result_exc     = out_e.exc;
  assign result_exccode = out_e.exccode;
  assign count          = count_q;

endmodule

// File: tb/tb_rvfpm_result_queue.sv
// tb/tb_rvfpm_result_queue.sv - scoreboard bench for rvfpm_result_queue
module tb_rvfpm_result_queue;

  logic        ck = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [3:0]  in_id;
  logic [31:0] in_data;
  logic [4:0]  in_rd;
  logic        in_we, in_exc;
  logic [5:0]  in_exccode;
  logic        commit_valid, commit_kill;
  logic [3:0]  commit_id;
  logic        result_valid, result_ready;
  logic [3:0]  result_id;
  logic [31:0] result_data;
  logic [4:0]  result_rd;
  logic        result_we, result_exc;
  logic [5:0]  result_exccode;
  logic [2:0]  count;

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        we;
    logic        exc;
    logic [5:0]  code;
  } res_t;

  res_t sb[$];
  int   total = 0;
  int   bad   = 0;

  rvfpm_result_queue #(.X_ID_WIDTH(4), .FLEN(32), .DEPTH(4)) dut (
    .ck(ck), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_data(in_data),
    .in_rd(in_rd), .in_we(in_we), .in_exc(in_exc), .in_exccode(in_exccode),
    .commit_valid(commit_valid), .commit_id(commit_id), .commit_kill(commit_kill),
    .result_valid(result_valid), .result_ready(result_ready), .result_id(result_id),
    .result_data(result_data), .result_rd(result_rd), .result_we(result_we),
    .result_exc(result_exc), .result_exccode(result_exccode), .count(count)
  );

  always #5 ck = ~ck;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted result must match the oldest expected entry.
  always @(negedge ck) begin
    if (rst === 1'b1 && result_valid === 1'b1 && result_ready === 1'b1) begin
      res_t act;
      act = '{id: result_id, data: result_data, rd: result_rd, we: result_we,
              exc: result_exc, code: result_exccode};
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got 0x%0h expected none", act);
      end else begin
        check("result", 64'(act), 64'(sb.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill);
    commit_valid = 1'b1;
    commit_id    = id;
    commit_kill  = kill;
    tick();
    commit_valid = 1'b0;
    commit_kill  = 1'b0;
  endtask

  task automatic push(input logic [3:0] id, input logic [31:0] data, input logic [4:0] rd,
                      input logic we, input logic exc, input logic [5:0] code,
                      input bit expect_out);
    in_valid   = 1'b1;
    in_id      = id;
    in_data    = data;
    in_rd      = rd;
    in_we      = we;
    in_exc     = exc;
    in_exccode = code;
    if (expect_out) sb.push_back('{id: id, data: data, rd: rd, we: we, exc: exc, code: code});
    check("push_in_ready", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0;
    in_valid = 0; in_id = 0; in_data = 0; in_rd = 0; in_we = 0; in_exc = 0; in_exccode = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0; result_ready = 0;
    tick();
    tick();
    check("rst_valid", 64'(result_valid), 64'(0));
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_count", 64'(count), 64'(0));
    check("rst_data", 64'(result_data), 64'(0));
    check("rst_id", 64'(result_id), 64'(0));
    rst = 1'b1;
    tick();

    // Basic release
    commit(4'd3, 1'b0);
    push(4'd3, 32'h3F800000, 5'd5, 1'b1, 1'b0, 6'd0, 1'b1);
    check("basic_valid", 64'(result_valid), 64'(1));
    check("basic_id", 64'(result_id), 64'(3));
    check("basic_data", 64'(result_data), 64'h3F800000);
    check("basic_rd", 64'(result_rd), 64'(5));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("basic_count", 64'(count), 64'(0));
    check("basic_hold_data", 64'(result_data), 64'h3F800000);

    // Wait then commit
    push(4'd1, 32'h40000000, 5'd6, 1'b1, 1'b0, 6'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      check("wait_valid", 64'(result_valid), 64'(0));
      tick();
    end
    check("wait_valid_last", 64'(result_valid), 64'(0));
    commit(4'd1, 1'b0);
    check("wait_commit_valid", 64'(result_valid), 64'(1));
    check("wait_id", 64'(result_id), 64'(1));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("wait_count", 64'(count), 64'(0));

    // Kill drop
    push(4'd2, 32'hDEAD0002, 5'd7, 1'b1, 1'b0, 6'd0, 1'b0);
    push(4'd4, 32'hBEEF0004, 5'd8, 1'b0, 1'b1, 6'd13, 1'b1);
    commit(4'd4, 1'b0);
    check("kill_wait_valid", 64'(result_valid), 64'(0));
    commit(4'd2, 1'b1);
    check("kill_drop_valid", 64'(result_valid), 64'(0));
    check("kill_drop_count", 64'(count), 64'(2));
    tick();
    check("kill_after_count", 64'(count), 64'(1));
    check("kill_rel_valid", 64'(result_valid), 64'(1));
    check("kill_rel_id", 64'(result_id), 64'(4));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("kill_count", 64'(count), 64'(0));

    // Full and backpressure
    for (int i = 0; i < 4; i++) commit(4'(i), 1'b0);
    for (int i = 0; i < 4; i++)
      push(4'(i), 32'hA0000000 + 32'(i), 5'(10 + i), 1'b1, 1'b0, 6'(i), 1'b1);
    check("full_in_ready", 64'(in_ready), 64'(0));
    check("full_count", 64'(count), 64'(4));
    in_valid = 1'b1;
    in_id    = 4'd5;
    in_data  = 32'h55555555;
    tick();
    in_valid = 1'b0;
    check("full_reject_count", 64'(count), 64'(4));
    result_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("full_rel_valid", 64'(result_valid), 64'(1));
      check("full_rel_id", 64'(result_id), 64'(i));
      tick();
    end
    result_ready = 1'b0;
    check("full_drain_count", 64'(count), 64'(0));

    // Wrap-around: push and pop every cycle
    for (int i = 0; i < 10; i++) commit(4'(i), 1'b0);
    result_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push(4'(i), 32'h10000000 + 32'(i * 17), 5'(i), 1'b1, 1'(i % 2), 6'(i), 1'b1);
      check("wrap_count", 64'(count), 64'(1));
    end
    tick();
    result_ready = 1'b0;
    check("wrap_drain_count", 64'(count), 64'(0));

    // Async reset mid-cycle
    for (int i = 5; i < 8; i++) commit(4'(i), 1'b0);
    for (int i = 5; i < 8; i++) push(4'(i), 32'(i), 5'(i), 1'b1, 1'b0, 6'd0, 1'b0);
    check("areset_pre_valid", 64'(result_valid), 64'(1));
    check("areset_pre_count", 64'(count), 64'(3));
    #2;
    rst = 1'b0;
    #1;
    check("areset_valid", 64'(result_valid), 64'(0));
    check("areset_count", 64'(count), 64'(0));
    check("areset_in_ready", 64'(in_ready), 64'(1));
    @(negedge ck);
    rst = 1'b1;
    tick();
    push(4'd0, 32'h12345678, 5'd1, 1'b1, 1'b0, 6'd0, 1'b1);
    tick();
    check("areset_new_wait", 64'(result_valid), 64'(0));
    commit(4'd0, 1'b0);
    check("areset_new_rel", 64'(result_valid), 64'(1));
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check("final_count", 64'(count), 64'(0));
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
